// File: rtl/sa_pkg.sv
// Shared types and constants for the SA dispatch/merge front end.
// Header layout is {protocol, dport, sport, dip, sip}, MSB first.
package sa_pkg;

  localparam int PKT_W = 104;
  localparam int RID_W = 14;

  localparam int SIP_LSB   = 0;
  localparam int DIP_LSB   = 32;
  localparam int SPORT_LSB = 64;
  localparam int DPORT_LSB = 80;
  localparam int PROTO_LSB = 96;

  typedef struct packed {
    logic [RID_W-1:0] rule_id;
    logic             hit;
  } sa_result_t;

endpackage

// File: rtl/sa_result_fifo.sv
// First-word-fall-through result buffer for one SA port.
// Wrap-bit pointers give full/empty and an occupancy count.
module sa_result_fifo
  import sa_pkg::*;
#(
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  sa_result_t wr_data,
  input  logic       rd_en,
  output sa_result_t rd_data,
  output logic       full,
  output logic       empty,
  output logic [AW:0] count
);

  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  sa_result_t  mem_q [DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic        do_wr, do_rd;

  // Status flags, head entry and pointer advance
  always_comb begin
    count    = wr_ptr_q - rd_ptr_q;
    full     = (count == FULL_CNT);
    empty    = (wr_ptr_q == rd_ptr_q);
    rd_data  = mem_q[rd_ptr_q[AW-1:0]];
    do_wr    = wr_en && !full;
    do_rd    = rd_en && !empty;
    wr_ptr_d = wr_ptr_q + (AW + 1)'(do_wr);
    rd_ptr_d = rd_ptr_q + (AW + 1)'(do_rd);
  end

  // Pointer registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage, no reset needed since empty masks it
  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
    end
  end

endmodule

// File: rtl/sa_dispatch_merge.sv
// Alternating dispatch of headers to two SA ports and in-order
// re-merge of their results, with credit-based admission.
module sa_dispatch_merge
  import sa_pkg::*;
#(
  parameter  int DEPTH = 16,
  localparam int CW    = $clog2(DEPTH) + 1,
  localparam int IW    = $clog2(2 * DEPTH) + 1
) (
  input  logic             clk,
  input  logic             RST,
  input  logic [PKT_W-1:0] pkt_in,
  input  logic             pkt_valid,
  output logic             pkt_ready,
  output logic [PKT_W-1:0] sa_packet_in1,
  output logic [PKT_W-1:0] sa_packet_in2,
  output logic             sa_data_valid_in1,
  output logic             sa_data_valid_in2,
  input  logic [RID_W-1:0] sa_rule_id1,
  input  logic [RID_W-1:0] sa_rule_id2,
  input  logic             sa_data_valid_out1,
  input  logic             sa_data_valid_out2,
  input  logic             sa_action_valid1,
  input  logic             sa_action_valid2,
  output logic [RID_W-1:0] res_rule_id,
  output logic             res_hit,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [IW-1:0]    inflight,
  output logic             err_overflow
);

  localparam logic [CW-1:0] CMAX = CW'(DEPTH);

  logic             disp_q, disp_d;
  logic             merge_q, merge_d;
  logic [CW-1:0]    cred0_q, cred0_d;
  logic [CW-1:0]    cred1_q, cred1_d;
  logic [PKT_W-1:0] pkt1_q, pkt1_d;
  logic [PKT_W-1:0] pkt2_q, pkt2_d;
  logic             vin1_q, vin1_d;
  logic             vin2_q, vin2_d;
  logic             err_q, err_d;

  logic             accept, pop;
  logic             inc0, inc1, pop0, pop1;
  logic             wr0, wr1;
  logic             full0, full1, empty0, empty1;
  logic [CW-1:0]    cnt0, cnt1;
  sa_result_t       res_in0, res_in1;
  sa_result_t       head0, head1, head;

  // Admission, merge head selection and FIFO write filtering
  always_comb begin
    pkt_ready = disp_q ? (cred1_q < CMAX) : (cred0_q < CMAX);
    accept    = pkt_valid && pkt_ready;
    inc0      = accept && !disp_q;
    inc1      = accept && disp_q;
    res_valid = merge_q ? !empty1 : !empty0;
    head      = merge_q ? head1 : head0;
    pop       = res_valid && res_ready;
    pop0      = pop && !merge_q;
    pop1      = pop && merge_q;
    res_in0   = '{rule_id: sa_rule_id1, hit: sa_action_valid1};
    res_in1   = '{rule_id: sa_rule_id2, hit: sa_action_valid2};
    // A strobe with no outstanding SA request is a stale pre-reset result
    wr0       = sa_data_valid_out1 && (cred0_q != cnt0);
    wr1       = sa_data_valid_out2 && (cred1_q != cnt1);
  end

  // Registered-state outputs
  always_comb begin
    res_rule_id       = res_valid ? head.rule_id : '0;
    res_hit           = res_valid && head.hit;
    inflight          = IW'(cred0_q) + IW'(cred1_q);
    err_overflow      = err_q;
    sa_packet_in1     = pkt1_q;
    sa_packet_in2     = pkt2_q;
    sa_data_valid_in1 = vin1_q;
    sa_data_valid_in2 = vin2_q;
  end

  // Next-state: pointers, credits, SA input registers, sticky error
  always_comb begin
    disp_d  = disp_q ^ accept;
    merge_d = merge_q ^ pop;
    unique case ({inc0, pop0})
      2'b10:   cred0_d = cred0_q + CW'(1);
      2'b01:   cred0_d = cred0_q - CW'(1);
      default: cred0_d = cred0_q;
    endcase
    unique case ({inc1, pop1})
      2'b10:   cred1_d = cred1_q + CW'(1);
      2'b01:   cred1_d = cred1_q - CW'(1);
      default: cred1_d = cred1_q;
    endcase
    pkt1_d = inc0 ? pkt_in : pkt1_q;
    pkt2_d = inc1 ? pkt_in : pkt2_q;
    vin1_d = inc0;
    vin2_d = inc1;
    err_d  = err_q
           | (sa_data_valid_out1 && full0)
           | (sa_data_valid_out2 && full1);
  end

  // State registers
  always_ff @(posedge clk) begin
    if (RST) begin
      disp_q  <= 1'b0;
      merge_q <= 1'b0;
      cred0_q <= '0;
      cred1_q <= '0;
      pkt1_q  <= '0;
      pkt2_q  <= '0;
      vin1_q  <= 1'b0;
      vin2_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      disp_q  <= disp_d;
      merge_q <= merge_d;
      cred0_q <= cred0_d;
      cred1_q <= cred1_d;
      pkt1_q  <= pkt1_d;
      pkt2_q  <= pkt2_d;
      vin1_q  <= vin1_d;
      vin2_q  <= vin2_d;
      err_q   <= err_d;
    end
  end

  sa_result_fifo #(.DEPTH(DEPTH)) u_fifo0 (
    .clk     (clk),
    .rst     (RST),
    .wr_en   (wr0),
    .wr_data (res_in0),
    .rd_en   (pop0),
    .rd_data (head0),
    .full    (full0),
    .empty   (empty0),
    .count   (cnt0)
  );

  sa_result_fifo #(.DEPTH(DEPTH)) u_fifo1 (
    .clk     (clk),
    .rst     (RST),
    .wr_en   (wr1),
    .wr_data (res_in1),
    .rd_en   (pop1),
    .rd_data (head1),
    .full    (full1),
    .empty   (empty1),
    .count   (cnt1)
  );

endmodule

// File: tb/tb_sa_dispatch_merge.sv
// Bench for sa_dispatch_merge: queue-based SA port model plus
// an arrival-order scoreboard and a credit-count reference.
module tb_sa_dispatch_merge;
  import sa_pkg::*;

  localparam int D = 16;

  logic             clk = 1'b0;
  logic             RST = 1'b1;
  logic [PKT_W-1:0] pkt_in = '0;
  logic             pkt_valid = 1'b0;
  logic             pkt_ready;
  logic [PKT_W-1:0] sa_packet_in1, sa_packet_in2;
  logic             sa_data_valid_in1, sa_data_valid_in2;
  logic [RID_W-1:0] mr1 = '0, mr2 = '0;
  logic             mv1 = 1'b0, mv2 = 1'b0;
  logic             mh1 = 1'b0, mh2 = 1'b0;
  logic             inj1 = 1'b0;
  logic             sa_data_valid_out1, sa_data_valid_out2;
  logic [RID_W-1:0] res_rule_id;
  logic             res_hit, res_valid;
  logic             res_ready = 1'b0;
  logic [5:0]       inflight;
  logic             err_overflow;

  assign sa_data_valid_out1 = mv1 | inj1;
  assign sa_data_valid_out2 = mv2;

  sa_dispatch_merge #(.DEPTH(D)) dut (
    .clk                (clk),
    .RST                (RST),
    .pkt_in             (pkt_in),
    .pkt_valid          (pkt_valid),
    .pkt_ready          (pkt_ready),
    .sa_packet_in1      (sa_packet_in1),
    .sa_packet_in2      (sa_packet_in2),
    .sa_data_valid_in1  (sa_data_valid_in1),
    .sa_data_valid_in2  (sa_data_valid_in2),
    .sa_rule_id1        (mr1),
    .sa_rule_id2        (mr2),
    .sa_data_valid_out1 (sa_data_valid_out1),
    .sa_data_valid_out2 (sa_data_valid_out2),
    .sa_action_valid1   (mh1),
    .sa_action_valid2   (mh2),
    .res_rule_id        (res_rule_id),
    .res_hit            (res_hit),
    .res_valid          (res_valid),
    .res_ready          (res_ready),
    .inflight           (inflight),
    .err_overflow       (err_overflow)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;
  int lat1 = 3;
  int lat2 = 3;

  typedef struct {
    int               due;
    logic [PKT_W-1:0] h;
  } sa_ent_t;
  sa_ent_t q1[$];
  sa_ent_t q2[$];

  typedef struct packed {
    logic [RID_W-1:0] rid;
    logic             hit;
  } exp_t;
  exp_t exp_q[$];

  // SA port model: fixed latency per port, the rule id and hit flag
  // are carried in the low bits of the header it was given.
  always @(negedge clk) begin
    mv1 = 1'b0;
    mv2 = 1'b0;
    if (q1.size() > 0 && q1[0].due <= cyc) begin
      mv1 = 1'b1;
      mr1 = q1[0].h[13:0];
      mh1 = q1[0].h[14];
      void'(q1.pop_front());
    end
    if (q2.size() > 0 && q2[0].due <= cyc) begin
      mv2 = 1'b1;
      mr2 = q2[0].h[13:0];
      mh2 = q2[0].h[14];
      void'(q2.pop_front());
    end
    if (sa_data_valid_in1 === 1'b1)
      q1.push_back('{cyc + lat1, sa_packet_in1});
    if (sa_data_valid_in2 === 1'b1)
      q2.push_back('{cyc + lat2, sa_packet_in2});
  end

  function automatic logic [PKT_W-1:0] mk_hdr(
    input logic [RID_W-1:0] rid, input logic hit);
    logic [127:0] r;
    r = {$urandom, $urandom, $urandom, $urandom};
    r[13:0] = rid;
    r[14] = hit;
    return r[PKT_W-1:0];
  endfunction

  task automatic test_reset();
    RST = 1'b1;
    pkt_valid = 1'b0;
    res_ready = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({pkt_ready, sa_data_valid_in1, sa_data_valid_in2,
         res_valid, res_hit, err_overflow} !== 6'b100000) begin
      n_err++;
      $display("FAIL reset_flags got %b%b%b%b%b%b want 100000",
        pkt_ready, sa_data_valid_in1, sa_data_valid_in2,
        res_valid, res_hit, err_overflow);
    end
    n_cmp++;
    if ((sa_packet_in1 | sa_packet_in2) !== '0) begin
      n_err++;
      $display("FAIL reset_pkts got %h/%h want 0",
        sa_packet_in1, sa_packet_in2);
    end
    n_cmp++;
    if (res_rule_id !== '0) begin
      n_err++;
      $display("FAIL reset_rid got %0d want 0", res_rule_id);
    end
    n_cmp++;
    if (inflight !== 6'd0) begin
      n_err++;
      $display("FAIL reset_inflight got %0d want 0", inflight);
    end
    RST = 1'b0;
  endtask

  task automatic test_directed();
    int ids[10] = '{3817, 4562, 4457, 4635, 4480,
                    4444, 6764, 6826, 4634, 7385};
    int sent = 0;
    int got = 0;
    int gaps = 0;
    bit started = 0;
    lat1 = 3;
    lat2 = 3;
    res_ready = 1'b1;
    for (int c = 0; c < 60 && got < 10; c++) begin
      @(negedge clk);
      if (res_valid) begin
        started = 1;
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL dir_extra got %0d want none", res_rule_id);
        end else begin
          if ({res_rule_id, res_hit} !== exp_q[0]) begin
            n_err++;
            $display("FAIL dir_order got %0d/%b want %0d/%b",
              res_rule_id, res_hit, exp_q[0].rid, exp_q[0].hit);
          end
          void'(exp_q.pop_front());
        end
        got++;
      end else if (started) begin
        gaps++;
      end
      pkt_valid = (sent < 10);
      if (pkt_valid) pkt_in = mk_hdr(14'(ids[sent]), 1'b1);
      if (pkt_valid && pkt_ready) begin
        exp_q.push_back('{rid: 14'(ids[sent]), hit: 1'b1});
        sent++;
      end
    end
    pkt_valid = 1'b0;
    n_cmp++;
    if (got != 10) begin
      n_err++;
      $display("FAIL dir_count got %0d want 10", got);
    end
    n_cmp++;
    if (gaps != 0) begin
      n_err++;
      $display("FAIL dir_gaps got %0d want 0", gaps);
    end
    n_cmp++;
    if (err_overflow !== 1'b0) begin
      n_err++;
      $display("FAIL dir_err got %b want 0", err_overflow);
    end
  endtask

  task automatic test_latency();
    logic [RID_W-1:0] rid;
    int c0;
    int seen = -1;
    rid = 14'($urandom);
    lat1 = 3;
    lat2 = 3;
    res_ready = 1'b1;
    @(negedge clk);
    pkt_in = mk_hdr(rid, 1'b0);
    pkt_valid = 1'b1;
    c0 = cyc;
    @(negedge clk);
    pkt_valid = 1'b0;
    for (int c = 0; c < 20 && seen < 0; c++) begin
      if (res_valid) begin
        seen = cyc;
        n_cmp++;
        if ({res_rule_id, res_hit} !== {rid, 1'b0}) begin
          n_err++;
          $display("FAIL lat_data got %0d/%b want %0d/0",
            res_rule_id, res_hit, rid);
        end
      end
      @(negedge clk);
    end
    n_cmp++;
    if (seen - c0 != lat1 + 2) begin
      n_err++;
      $display("FAIL lat_cycles got %0d want %0d", seen - c0, lat1 + 2);
    end
    n_cmp++;
    if (res_valid !== 1'b0 || inflight !== 6'd0) begin
      n_err++;
      $display("FAIL lat_after got v=%b inf=%0d want v=0 inf=0",
        res_valid, inflight);
    end
  endtask

  task automatic test_backpressure();
    int acc = 0;
    int popped = 0;
    lat1 = 3;
    lat2 = 3;
    res_ready = 1'b0;
    for (int c = 0; c < 70; c++) begin
      @(negedge clk);
      pkt_valid = 1'b1;
      pkt_in = mk_hdr(14'($urandom), 1'($urandom));
      if (pkt_ready) begin
        exp_q.push_back('{rid: pkt_in[13:0], hit: pkt_in[14]});
        acc++;
      end
    end
    n_cmp++;
    if (acc != 2 * D) begin
      n_err++;
      $display("FAIL bp_accepts got %0d want %0d", acc, 2 * D);
    end
    n_cmp++;
    if (pkt_ready !== 1'b0 || inflight !== 6'(2 * D)) begin
      n_err++;
      $display("FAIL bp_full got rdy=%b inf=%0d want rdy=0 inf=%0d",
        pkt_ready, inflight, 2 * D);
    end
    pkt_valid = 1'b0;
    res_ready = 1'b1;
    for (int c = 0; c < 80 && popped < 2 * D; c++) begin
      if (c == 1) begin
        n_cmp++;
        if (pkt_ready !== 1'b1) begin
          n_err++;
          $display("FAIL bp_ready_return got %b want 1", pkt_ready);
        end
      end
      if (res_valid) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL bp_extra got %0d want none", res_rule_id);
        end else begin
          if ({res_rule_id, res_hit} !== exp_q[0]) begin
            n_err++;
            $display("FAIL bp_order got %0d/%b want %0d/%b",
              res_rule_id, res_hit, exp_q[0].rid, exp_q[0].hit);
          end
          void'(exp_q.pop_front());
        end
        popped++;
      end
      @(negedge clk);
    end
    n_cmp++;
    if (popped != 2 * D || inflight !== 6'd0) begin
      n_err++;
      $display("FAIL bp_drain got pops=%0d inf=%0d want %0d/0",
        popped, inflight, 2 * D);
    end
  endtask

  task automatic test_skew();
    int sent = 0;
    int got = 0;
    bit dropped = 0;
    lat1 = 2;
    lat2 = 7;
    res_ready = 1'b1;
    for (int c = 0; c < 150 && got < 12; c++) begin
      @(negedge clk);
      if (res_valid) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL skew_extra got %0d want none", res_rule_id);
        end else begin
          if ({res_rule_id, res_hit} !== exp_q[0]) begin
            n_err++;
            $display("FAIL skew_order got %0d/%b want %0d/%b",
              res_rule_id, res_hit, exp_q[0].rid, exp_q[0].hit);
          end
          void'(exp_q.pop_front());
        end
        got++;
      end else if (got > 0 && exp_q.size() > 0) begin
        dropped = 1;
      end
      pkt_valid = (sent < 12) && ($urandom_range(0, 1) == 1);
      pkt_in = mk_hdr(14'($urandom), 1'($urandom));
      if (pkt_valid && pkt_ready) begin
        exp_q.push_back('{rid: pkt_in[13:0], hit: pkt_in[14]});
        sent++;
      end
    end
    pkt_valid = 1'b0;
    n_cmp++;
    if (got != 12) begin
      n_err++;
      $display("FAIL skew_count got %0d want 12", got);
    end
    n_cmp++;
    if (dropped != 1'b1) begin
      n_err++;
      $display("FAIL skew_gap got %b want 1", dropped);
    end
  endtask

  task automatic test_reset_midflight();
    int sent = 0;
    int bad = 0;
    int seen = 0;
    logic [PKT_W-1:0] h;
    lat1 = 4;
    lat2 = 4;
    res_ready = 1'b0;
    for (int c = 0; c < 20 && sent < 6; c++) begin
      @(negedge clk);
      pkt_valid = 1'b1;
      pkt_in = mk_hdr(14'($urandom), 1'b1);
      if (pkt_ready) sent++;
    end
    @(negedge clk);
    pkt_valid = 1'b0;
    RST = 1'b1;
    @(negedge clk);
    RST = 1'b0;
    exp_q.delete();
    n_cmp++;
    if ({pkt_ready, sa_data_valid_in1, sa_data_valid_in2,
         res_valid, res_hit, err_overflow} !== 6'b100000
        || inflight !== 6'd0 || res_rule_id !== '0
        || (sa_packet_in1 | sa_packet_in2) !== '0) begin
      n_err++;
      $display("FAIL mid_reset got rdy=%b v=%b inf=%0d rid=%0d want 1/0/0/0",
        pkt_ready, res_valid, inflight, res_rule_id);
    end
    res_ready = 1'b1;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (res_valid !== 1'b0 || inflight !== 6'd0) bad++;
    end
    n_cmp++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL mid_stale got %0d bad cycles want 0", bad);
    end
    h = mk_hdr(14'($urandom), 1'b1);
    pkt_in = h;
    pkt_valid = 1'b1;
    @(negedge clk);
    pkt_valid = 1'b0;
    n_cmp++;
    if ({sa_data_valid_in1, sa_data_valid_in2} !== 2'b10
        || sa_packet_in1 !== h) begin
      n_err++;
      $display("FAIL mid_port1 got v=%b%b want 10",
        sa_data_valid_in1, sa_data_valid_in2);
    end
    for (int c = 0; c < 20 && seen == 0; c++) begin
      @(negedge clk);
      if (res_valid) seen = 1;
    end
    n_cmp++;
    if (seen != 1 || res_rule_id !== h[13:0]) begin
      n_err++;
      $display("FAIL mid_result got seen=%0d rid=%0d want 1/%0d",
        seen, res_rule_id, h[13:0]);
    end
    @(negedge clk);
  endtask

  task automatic test_overflow();
    int acc = 0;
    lat1 = 2;
    lat2 = 2;
    res_ready = 1'b0;
    RST = 1'b1;
    @(negedge clk);
    RST = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      pkt_valid = 1'b1;
      pkt_in = mk_hdr(14'($urandom), 1'b1);
      if (pkt_ready) acc++;
    end
    pkt_valid = 1'b0;
    repeat (5) @(negedge clk);
    n_cmp++;
    if (acc != 2 * D || err_overflow !== 1'b0) begin
      n_err++;
      $display("FAIL ovf_pre got acc=%0d err=%b want %0d/0",
        acc, err_overflow, 2 * D);
    end
    inj1 = 1'b1;
    @(negedge clk);
    inj1 = 1'b0;
    n_cmp++;
    if (err_overflow !== 1'b1) begin
      n_err++;
      $display("FAIL ovf_set got %b want 1", err_overflow);
    end
    repeat (5) @(negedge clk);
    n_cmp++;
    if (err_overflow !== 1'b1) begin
      n_err++;
      $display("FAIL ovf_sticky got %b want 1", err_overflow);
    end
    RST = 1'b1;
    @(negedge clk);
    RST = 1'b0;
    n_cmp++;
    if (err_overflow !== 1'b0) begin
      n_err++;
      $display("FAIL ovf_clear got %b want 0", err_overflow);
    end
  endtask

  task automatic test_random();
    int acc = 0;
    int pops = 0;
    int p, a_p, o_p;
    bit rdy_exp;
    lat1 = 3;
    lat2 = 5;
    exp_q.delete();
    for (int c = 0; c < 340; c++) begin
      @(negedge clk);
      p = acc % 2;
      a_p = p ? acc / 2 : (acc + 1) / 2;
      o_p = p ? pops / 2 : (pops + 1) / 2;
      rdy_exp = (a_p - o_p) < D;
      n_cmp++;
      if (pkt_ready !== rdy_exp || inflight !== 6'(acc - pops)) begin
        n_err++;
        $display("FAIL rnd_credit got rdy=%b inf=%0d want %b/%0d",
          pkt_ready, inflight, rdy_exp, acc - pops);
      end
      res_ready = (c >= 300) || ($urandom_range(0, 2) != 0);
      if (res_valid) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL rnd_extra got %0d want none", res_rule_id);
        end else if ({res_rule_id, res_hit} !== exp_q[0]) begin
          n_err++;
          $display("FAIL rnd_order got %0d/%b want %0d/%b",
            res_rule_id, res_hit, exp_q[0].rid, exp_q[0].hit);
        end
        if (res_ready) begin
          if (exp_q.size() > 0) void'(exp_q.pop_front());
          pops++;
        end
      end
      pkt_valid = (c < 300) && ($urandom_range(0, 3) != 0);
      pkt_in = mk_hdr(14'($urandom), 1'($urandom));
      if (pkt_valid && pkt_ready) begin
        exp_q.push_back('{rid: pkt_in[13:0], hit: pkt_in[14]});
        acc++;
      end
    end
    pkt_valid = 1'b0;
    n_cmp++;
    if (exp_q.size() != 0 || err_overflow !== 1'b0) begin
      n_err++;
      $display("FAIL rnd_drain got left=%0d err=%b want 0/0",
        exp_q.size(), err_overflow);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_latency();
    test_backpressure();
    test_skew();
    test_reset_midflight();
    test_overflow();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
      n_cmp, n_err);
    $finish;
  end

endmodule
